// File: rtl/fifo_fwft_pf.sv
// fifo_fwft_pf: FWFT sync FIFO (RAM + latency-hiding prefetch buffer) with thresholds, error pulses and count
module fifo_fwft_pf #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int RD_LAT = 1,
  parameter int AF_THRESH = FIFO_DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int B = RD_LAT + 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $fatal(1, "fifo_fwft_pf: FIFO_DEPTH must be a power of two >= 4");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_lat_chk
    $fatal(1, "fifo_fwft_pf: RD_LAT must be 1 or 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH)) begin : g_thr_chk
    $fatal(1, "fifo_fwft_pf: need AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pd [RD_LAT];
  logic [DATA_WIDTH-1:0] pbuf [B];
  logic [DATA_WIDTH-1:0] pbuf_n [B];
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [RD_LAT-1:0] pv;
  logic [1:0] bcnt, bcnt_n, inflight, widx;
  logic [CW-1:0] count_n;
  logic wr_acc, rd_acc, issue, arrive;
  assign wr_acc = wen && !full;
  assign rd_acc = ren && !empty;
  assign arrive = pv[RD_LAT-1];
  assign inflight = {1'b0, pv[0]} + (RD_LAT == 2 ? {1'b0, pv[RD_LAT-1]} : 2'd0);
  assign issue = (wptr != rptr) && ({1'b0, bcnt} + {1'b0, inflight} - {2'b0, rd_acc}) < 3'(B);
  assign widx = bcnt - {1'b0, rd_acc};
  assign bcnt_n = bcnt + {1'b0, arrive} - {1'b0, rd_acc};
  assign count_n = count + CW'(wr_acc) - CW'(rd_acc);
  assign rdata = pbuf[0];
  always_comb begin
    for (int i = 0; i < B; i++)
      pbuf_n[i] = (arrive && widx == 2'(i)) ? pd[RD_LAT-1] :
                  (rd_acc && i < B - 1) ? pbuf[(i + 1) % B] : pbuf[i];
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    pd[0] <= mem[rptr[ADDR_WIDTH-1:0]];
    for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      pv <= '0;
      bcnt <= '0;
      count <= '0;
      for (int i = 0; i < B; i++) pbuf[i] <= '0;
      full <= 1'b0;
      almost_full <= AF_THRESH == 0;
      almost_empty <= 1'b1;
      empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wptr + CW'(wr_acc);
      rptr <= rptr + CW'(issue);
      pv <= RD_LAT'({pv, issue});
      bcnt <= bcnt_n;
      count <= count_n;
      pbuf <= pbuf_n;
      full <= count_n == DEPTH_C;
      almost_full <= count_n >= AF_C;
      almost_empty <= count_n <= AE_C;
      empty <= bcnt_n == 2'd0;
      overflow <= wen && full;
      underflow <= ren && empty;
    end
  end
endmodule
